result_collector: RTL

Output-side companion to the systolic-array scheduler. While the scheduler drives weights and multiply enables into the array, this block receives the skewed partial-sum results leaving the bottom of each column. It re-aligns them into complete output-matrix rows, buffers them per column, and streams rows to the host over a valid/ready handshake. It asserts `done` after the last row is accepted.

---
 rtl/result_collector_if.sv | 22 ++
 rtl/result_collector.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/result_collector_if.sv
// Result streams around the collector: skewed column results in, aligned output rows out.
interface result_collector_if #(
  parameter int unsigned MATRIX_SIZE = 2,
  parameter int unsigned DATA_SIZE   = 32
);
  logic [MATRIX_SIZE-1:0]           col_valid;
  logic [MATRIX_SIZE*DATA_SIZE-1:0] col_data;
  logic                             out_valid;
  logic                             out_ready;
  logic [MATRIX_SIZE*DATA_SIZE-1:0] out_data;
  logic                             out_last;

  modport master (
    output col_valid, col_data, out_ready,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  col_valid, col_data, out_ready,
    output out_valid, out_data, out_last
  );
endinterface

// File: rtl/result_collector.sv
// Re-aligns skewed systolic column results into output rows and streams them out.
// Optional COLLECT_RELU_EN: clamp negative elements to zero as rows are loaded.
module result_collector #(
  parameter int unsigned MATRIX_SIZE = 2,
  parameter int unsigned DATA_SIZE   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                general_enable,
  input  logic                start,
  result_collector_if.slave   bus,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  localparam int unsigned PtrW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam int unsigned CntW = $clog2(MATRIX_SIZE) + 1;
  localparam logic [PtrW-1:0] PtrMax  = PtrW'(MATRIX_SIZE - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(MATRIX_SIZE);
  localparam logic [CntW-1:0] RowLast = CntW'(MATRIX_SIZE - 1);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e                           state_q, state_d;
  logic [DATA_SIZE-1:0]             mem_q [MATRIX_SIZE][MATRIX_SIZE];
  logic [PtrW-1:0]                  wr_ptr_q [MATRIX_SIZE];
  logic [PtrW-1:0]                  wr_ptr_d [MATRIX_SIZE];
  logic [PtrW-1:0]                  rd_ptr_q [MATRIX_SIZE];
  logic [PtrW-1:0]                  rd_ptr_d [MATRIX_SIZE];
  logic [CntW-1:0]                  cnt_q [MATRIX_SIZE];
  logic [CntW-1:0]                  cnt_d [MATRIX_SIZE];
  logic [CntW-1:0]                  row_cnt_q, row_cnt_d;
  logic [CntW-1:0]                  row_idx;
  logic                             out_valid_q, out_valid_d;
  logic                             out_last_q, out_last_d;
  logic [MATRIX_SIZE*DATA_SIZE-1:0] out_data_q, out_data_d;
  logic                             done_q, done_d;
  logic                             overflow_q, overflow_d;
  logic [MATRIX_SIZE-1:0]           push;
  logic [MATRIX_SIZE-1:0]           full;
  logic [MATRIX_SIZE-1:0]           non_empty;
  logic                             active;
  logic                             form;
  logic                             xfer;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrMax) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [DATA_SIZE-1:0] shape(input logic [DATA_SIZE-1:0] v);
`ifdef COLLECT_RELU_EN
    return v[DATA_SIZE-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    for (int j = 0; j < MATRIX_SIZE; j++) begin
      full[j]      = (cnt_q[j] == CntFull);
      non_empty[j] = (cnt_q[j] != '0);
    end
  end

  assign active = (state_q == StActive);
  // Index of the row about to be loaded: one past the counter if the held row leaves now.
  assign row_idx = out_valid_q ? row_cnt_q + 1'b1 : row_cnt_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    row_cnt_d   = row_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    push        = '0;
    form        = 1'b0;
    xfer        = 1'b0;

    if (general_enable) begin
      if (start) begin
        state_d     = StActive;
        wr_ptr_d    = '{default: '0};
        rd_ptr_d    = '{default: '0};
        cnt_d       = '{default: '0};
        row_cnt_d   = '0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        done_d      = 1'b0;
        overflow_d  = 1'b0;
      end else begin
        xfer = out_valid_q && bus.out_ready;
        // No new row once the last row of the job is already held.
        form = active && (!out_valid_q || bus.out_ready) && (&non_empty) &&
               !(out_valid_q && out_last_q);

        for (int j = 0; j < MATRIX_SIZE; j++) begin
          if (active && bus.col_valid[j]) begin
            if (!full[j] || form) begin
              push[j] = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end
          if (push[j]) begin
            wr_ptr_d[j] = ptr_inc(wr_ptr_q[j]);
          end
          if (form) begin
            rd_ptr_d[j] = ptr_inc(rd_ptr_q[j]);
          end
          cnt_d[j] = cnt_q[j] + CntW'(push[j]) - CntW'(form);
        end

        if (xfer) begin
          row_cnt_d   = row_cnt_q + 1'b1;
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end

        if (form) begin
          out_valid_d = 1'b1;
          out_last_d  = (row_idx == RowLast);
          for (int j = 0; j < MATRIX_SIZE; j++) begin
            out_data_d[j*DATA_SIZE +: DATA_SIZE] = shape(mem_q[j][rd_ptr_q[j]]);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '{default: '0};
      rd_ptr_q    <= '{default: '0};
      cnt_q       <= '{default: '0};
      row_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      row_cnt_q   <= row_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    for (int j = 0; j < MATRIX_SIZE; j++) begin
      if (reset && push[j]) begin
        mem_q[j][wr_ptr_q[j]] <= bus.col_data[j*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign busy          = active;
  assign done          = done_q;
  assign overflow      = overflow_q;

endmodule
